// File: rtl/profile_arbiter_if.sv
// ---------------------------------------------------------------------------
// profile_arbiter_if
// Request/grant bundle between the user-request front end (master) and the
// profile arbiter (slave).
//   req        : per-user level request, held while the resource is wanted
//   prof       : 2-bit profile of user i at prof[2i+1:2i] (higher = stronger)
//   grant      : registered one-hot grant, all-zero when the resource is free
//   busy       : registered, high while any grant bit is set
//   owner_prof : profile latched for the current owner, 0 when free
//   preempt    : one-cycle pulse when the owner is revoked by a stronger user
// ---------------------------------------------------------------------------
interface profile_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [2*N-1:0] prof;
  logic [N-1:0]   grant;
  logic           busy;
  logic [1:0]     owner_prof;
  logic           preempt;

  modport master (
    output req, prof,
    input  grant, busy, owner_prof, preempt
  );

  modport slave (
    input  req, prof,
    output grant, busy, owner_prof, preempt
  );
endinterface

// File: rtl/profile_arbiter.sv
// ---------------------------------------------------------------------------
// profile_arbiter
// Grants one shared resource to one of N users ranked by 2-bit profile.
// A challenger preempts the owner only with a strictly greater profile and
// only after the owner has held the grant for MIN_HOLD cycles. Every handover
// passes through a one-cycle GAP with no grant (break-before-make).
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : profile_arbiter_if.slave (req/prof in; grant/busy/owner_prof/
//           preempt out, all outputs registered)
//
// Optional feature (macro PROF_AGING_EN): each waiting user ages; after
// AGE_LIMIT cycles of waiting its effective profile becomes 2'b11 for winner
// selection and the preempt comparison. Without the macro AGE_LIMIT is only
// range-checked and the effective profile is the raw profile.
// ---------------------------------------------------------------------------
module profile_arbiter #(
  parameter int N         = 4,
  parameter int MIN_HOLD  = 4,
  parameter int AGE_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  profile_arbiter_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

  if (N < 2 || N > 8 || MIN_HOLD < 1 || AGE_LIMIT < 1) begin : g_bad_cfg
    $error("profile_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] owner_idx;

  logic [1:0]    eff_prof [N];
  logic          any_req;
  logic [IW-1:0] win_idx;
  logic [1:0]    win_prof;
  logic          challenge;
  logic          owner_req;

  // Effective profile per user.
`ifdef PROF_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

  logic [AW-1:0] wait_cnt [N];

  // NOTE: the wait counters are a handful of flops, not a RAM, so they are
  // reset along with the rest of the state; a true memory array would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] || bus.grant[i]) wait_cnt[i] <= '0;
        else if (wait_cnt[i] != AGE_MAX)  wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      eff_prof[i] = (wait_cnt[i] == AGE_MAX) ? 2'b11 : bus.prof[2*i +: 2];
  end
`else
  always_comb begin
    for (int i = 0; i < N; i++) eff_prof[i] = bus.prof[2*i +: 2];
  end
`endif

  // Winner: highest effective profile among requesters; strict '>' keeps the
  // lowest index on ties.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    any_req  = 1'b0;
    win_idx  = '0;
    win_prof = 2'b00;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i] && (!any_req || eff_prof[i] > win_prof)) begin
        any_req  = 1'b1;
        win_idx  = IW'(i);
        win_prof = eff_prof[i];
      end
    end
  end

  // A challenger must beat the latched owner profile, not the owner's live one.
  always_comb begin
    challenge = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (bus.req[j] && (IW'(j) != owner_idx) && (eff_prof[j] > bus.owner_prof))
        challenge = 1'b1;
    end
  end

  assign owner_req = bus.req[owner_idx];

  // NOTE: all state and outputs here use non-blocking assignments so every
  // register samples the pre-edge values and simulation matches hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      owner_idx      <= '0;
      bus.grant      <= '0;
      bus.busy       <= 1'b0;
      bus.owner_prof <= 2'b00;
      bus.preempt    <= 1'b0;
    end else begin
      bus.preempt <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (any_req) begin
            state          <= HOLD;
            hold_cnt       <= HW'(1);
            owner_idx      <= win_idx;
            bus.grant      <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            bus.busy       <= 1'b1;
            bus.owner_prof <= win_prof;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          // Release is tested first so it wins over a simultaneous preempt.
          if (!owner_req || (challenge && hold_cnt >= HOLD_MAX)) begin
            state          <= GAP;
            hold_cnt       <= '0;
            bus.grant      <= '0;
            bus.busy       <= 1'b0;
            bus.owner_prof <= 2'b00;
            bus.preempt    <= owner_req;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/profile_arbiter.md
Name: profile_arbiter

Overview:
Grants one shared controlled resource to one of N requesting users, ranked by their 2-bit profile level (higher value = higher privilege).
- Sits between the user-request front end and the resource actuator.
- Applies the "challenger profile strictly greater than owner profile" rule internally, with one-hot grant.
- Guarantees minimum hold time, break-before-make handover and strict-priority preemption.

Parameters:
N, 4, number of requesters (2..8)
MIN_HOLD, 4, minimum cycles an owner keeps GRANT before it can be preempted (>=1)
AGE_LIMIT, 16, wait cycles before aging boost; used only with PROF_AGING_EN

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
REQ  input  N  request per user, level, held while resource wanted
PROF  input  2*N  profile of user i at PROF[2i+1:2i]
GRANT  output  N  registered one-hot grant; all-zero when free
BUSY  output  1  registered; 1 while any GRANT bit set
OWNER_PROF  output  2  profile of current owner latched at grant; 0 when free
PREEMPT  output  1  registered one-cycle pulse when the owner is revoked by preemption

Behaviour:
- Reset: RST_N low immediately forces GRANT=0, BUSY=0, OWNER_PROF=0, PREEMPT=0, state IDLE, hold counter 0. Reset mid-HOLD drops the grant with no PREEMPT pulse.
- Winner selection (combinational on current REQ/PROF): highest PROF among asserted REQ; ties go to the lowest index.
- States: IDLE, HOLD, GAP.
- IDLE:
  - If any REQ=1 at a clock edge, GRANT=onehot(winner), OWNER_PROF=PROF[winner], hold_cnt=1, next state HOLD.
  - Latency is one edge: REQ sampled at edge k gives GRANT high after edge k.
  - Otherwise stay in IDLE.
- HOLD:
  - hold_cnt increments each cycle and saturates at MIN_HOLD (width clog2(MIN_HOLD+1)).
  - Release: REQ[owner]=0 at an edge → GRANT=0, OWNER_PROF=0, go to GAP. PREEMPT stays 0.
  - Preempt: REQ[owner]=1, and some other requester j has REQ[j]=1 with PROF[j] > OWNER_PROF, and hold_cnt >= MIN_HOLD → GRANT=0, OWNER_PROF=0, PREEMPT=1 for exactly one cycle, go to GAP.
  - An equal-profile challenger never preempts.
  - If release and preempt conditions hold on the same edge, release wins (PREEMPT=0).
  - Profile changes of the owner during HOLD are ignored; OWNER_PROF stays latched.
- GAP:
  - Exactly one cycle with GRANT=0 (break-before-make).
  - At the end of GAP, arbitrate as in IDLE: grant the winner and go to HOLD, or go to IDLE if no REQ.
  - The preempted owner still requesting competes normally.
- Release-to-next-grant: owner REQ drop sampled at edge E0 → GRANT=0 after E0 → new GRANT after E1.
- Output invariants:
  - GRANT is never multi-hot.
  - BUSY equals |GRANT.
  - PREEMPT never coincides with nonzero GRANT.
- A requester that drops REQ before being granted is simply not considered; there is no queued memory.

Optional Feature:
PROF_AGING_EN
- Defined:
  - Each requester has a wait counter that increments while REQ=1 and not granted, saturating at AGE_LIMIT.
  - The counter clears on its own grant or on REQ=0.
  - Once the counter reaches AGE_LIMIT, the requester's effective profile is 2'b11 for winner selection and for the preempt comparison.
  - OWNER_PROF latches the effective profile at grant.
  - Tie rule (lowest index) is unchanged.
- Undefined: no wait counters, and effective profile equals PROF. AGE_LIMIT is unused.

Test Plan:
1. N=4, MIN_HOLD=4, idle. REQ=0010, PROF[3:2]=01 sampled at edge 1 → after edge 1: GRANT=0010, BUSY=1, OWNER_PROF=01, PREEMPT=0.
2. Tie. REQ=0101, PROF0=10, PROF2=10 from IDLE → GRANT=0001; holding both REQs for 20 cycles never moves the grant.
3. Preempt. User1 (01) owns the resource; REQ3 with PROF3=11 rises at hold_cnt=2 → no change until hold_cnt=4. Then PREEMPT=1 for one cycle with GRANT=0000, then GRANT=1000 with OWNER_PROF=11. User1 keeps REQ and waits.
4. Release. Owner user3 drops REQ while user0 (00) waits → GRANT=0000 for exactly one cycle, then GRANT=0001 with PREEMPT=0. If no one waits, BUSY=0 and the block returns to IDLE.
5. Async reset. RST_N pulsed low mid-HOLD between clock edges → GRANT, BUSY, OWNER_PROF and PREEMPT go to 0 before the next edge. After release, the first REQ is granted one edge later.
6. With PROF_AGING_EN, AGE_LIMIT=16. User3 (11) holds continuously while user0 (00) waits; user2 (01) joins later → user0 reaches age 16, effective profile 11, which is not greater than 11, so no preempt. After user3 releases, user0 wins over user2 and OWNER_PROF=11.
